// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-style control unit.
//   - opcode constants for the supported instruction set
//   - 4-bit state encoding (also exported on the debug state port)
//   - ALUOp, ALUSrcB and PCSource select codes
//   - is_mem_state(): states that issue a memory access and so can time out
package mc_pkg;

  // instruction[31:26] values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // ALU operation requested from the ALU control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand selects
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  // next-PC selects
  localparam logic [1:0] PCSRC_ALU   = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP  = 2'b10;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle datapath controller (FETCH/DECODE/execute sequence).
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   opcode[5:0]       instruction[31:26], sampled only in DECODE
//   mem_ready         memory finishes the current access this cycle
//   PCWrite .. RegDst 1-bit datapath enables/selects
//   ALUOp, ALUSrcB, PCSource  2-bit datapath selects
//   state[3:0]        current state (debug)
//   trap              sticky: illegal opcode or memory wait timeout
// A memory state that sees mem_ready low for WAIT_LIMIT+1 consecutive
// cycles moves to TRAP, where every control is 0 until reset.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       trap
);

  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(WAIT_LIMIT);

  state_t          state_reg, state_next;
  logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [5:0]      opcode_reg;
  logic            trap_reg;
  logic            timeout;

  // Counter has reached the limit and memory is still not ready.
  assign timeout = is_mem_state(state_reg) && !mem_ready && (wait_cnt_reg == WAIT_MAX);

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
      opcode_reg   <= '0;
      trap_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == S_DECODE) begin
        opcode_reg <= opcode;
      end
      if (state_next == S_TRAP) begin
        trap_reg <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: begin
        if (mem_ready)    state_next = S_DECODE;
        else if (timeout) state_next = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = S_RTYPE_EX;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BEQ;
          OP_ADDI:      state_next = S_ADDI_EX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_TRAP;
        endcase
      end
      // opcode input has moved on by now; use the copy taken in DECODE
      S_MEMADR:   state_next = (opcode_reg == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)    state_next = S_MEMWB;
        else if (timeout) state_next = S_TRAP;
      end
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)    state_next = S_FETCH;
        else if (timeout) state_next = S_TRAP;
      end
      S_RTYPE_EX: state_next = S_RTYPE_WB;
      S_RTYPE_WB: state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_ADDI_EX:  state_next = S_ADDI_WB;
      S_ADDI_WB:  state_next = S_FETCH;
      S_JUMP:     state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_TRAP;
    endcase
  end

  // Wait counter: counts only while stalled in the same memory state.
  // Any transition (including entry to a memory state) or mem_ready=1
  // leaves it at zero.
  always_comb begin
    wait_cnt_next = '0;
    if (is_mem_state(state_reg) && !mem_ready && (state_next == state_reg)) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  // --------------------------------------------------------------- outputs
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = SRCB_REG;
    PCSource    = PCSRC_ALU;
    case (state_reg)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        // PC+4 and IR are captured only when the fetch actually completes
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
      end
      S_MEMADR, S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_RTYPE_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign state = state_reg;
  assign trap  = trap_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction sequences, memory
// stalls, timeout boundary, illegal opcode and reset recovery.
module tb_multicycle_control;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] ALUOp, ALUSrcB, PCSource;
  logic [3:0] state;
  logic       trap;

  int checks_total  = 0;
  int checks_passed = 0;

  // Packed controls: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,
  //                   IRWrite,ALUSrcA,RegWrite,RegDst,ALUOp,ALUSrcB,PCSource}
  logic [15:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                 IRWrite, ALUSrcA, RegWrite, RegDst, ALUOp, ALUSrcB, PCSource};

  // Hand-derived control words
  localparam logic [15:0] C_FETCH_RDY = 16'h9204;
  localparam logic [15:0] C_FETCH_WT  = 16'h1004;
  localparam logic [15:0] C_DECODE    = 16'h000C;
  localparam logic [15:0] C_MEMADR    = 16'h0108;
  localparam logic [15:0] C_MEMRD     = 16'h3000;
  localparam logic [15:0] C_MEMWB     = 16'h0480;
  localparam logic [15:0] C_MEMWR     = 16'h2800;
  localparam logic [15:0] C_RTYPE_EX  = 16'h0120;
  localparam logic [15:0] C_RTYPE_WB  = 16'h00C0;
  localparam logic [15:0] C_BEQ       = 16'h4111;
  localparam logic [15:0] C_ADDI_EX   = 16'h0108;
  localparam logic [15:0] C_ADDI_WB   = 16'h0080;
  localparam logic [15:0] C_JUMP      = 16'h8002;
  localparam logic [15:0] C_NONE      = 16'h0000;

  multicycle_control #(.WAIT_LIMIT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .state(state), .trap(trap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
      $display("ok   %-16s got 0x%0h", tag, obs);
    end else begin
      $display("FAIL %-16s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check state and controls for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input state_t st, input logic [15:0] ct);
    #1;
    check({tag, "_st"}, 32'(state), 32'(st));
    check({tag, "_ctl"}, 32'(ctrl), 32'(ct));
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'(S_FETCH));
    check("rst_trap", 32'(trap), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b1;
    opcode    = OP_RTYPE;
    tick();
    #1;
    // outputs while rst still high equal FETCH values
    check("in_rst_state", 32'(state), 32'(S_FETCH));
    check("in_rst_ctrl", 32'(ctrl), 32'(C_FETCH_RDY));
    check("in_rst_trap", 32'(trap), 32'd0);
    rst = 1'b0;

    // lw: opcode corrupted after DECODE to prove the latched copy is used
    opcode = OP_LW;
    cyc("lw_fetch", S_FETCH, C_FETCH_RDY);
    cyc("lw_decode", S_DECODE, C_DECODE);
    opcode = OP_RTYPE;
    cyc("lw_memadr", S_MEMADR, C_MEMADR);
    cyc("lw_memrd", S_MEMRD, C_MEMRD);
    cyc("lw_memwb", S_MEMWB, C_MEMWB);

    // sw
    opcode = OP_SW;
    cyc("sw_fetch", S_FETCH, C_FETCH_RDY);
    cyc("sw_decode", S_DECODE, C_DECODE);
    opcode = OP_LW;
    cyc("sw_memadr", S_MEMADR, C_MEMADR);
    cyc("sw_memwr", S_MEMWR, C_MEMWR);

    // R-type
    opcode = OP_RTYPE;
    cyc("r_fetch", S_FETCH, C_FETCH_RDY);
    cyc("r_decode", S_DECODE, C_DECODE);
    cyc("r_ex", S_RTYPE_EX, C_RTYPE_EX);
    cyc("r_wb", S_RTYPE_WB, C_RTYPE_WB);

    // addi
    opcode = OP_ADDI;
    cyc("addi_fetch", S_FETCH, C_FETCH_RDY);
    cyc("addi_decode", S_DECODE, C_DECODE);
    cyc("addi_ex", S_ADDI_EX, C_ADDI_EX);
    cyc("addi_wb", S_ADDI_WB, C_ADDI_WB);

    // beq
    opcode = OP_BEQ;
    cyc("beq_fetch", S_FETCH, C_FETCH_RDY);
    cyc("beq_decode", S_DECODE, C_DECODE);
    cyc("beq_exec", S_BEQ, C_BEQ);

    // j
    opcode = OP_J;
    cyc("j_fetch", S_FETCH, C_FETCH_RDY);
    cyc("j_decode", S_DECODE, C_DECODE);
    cyc("j_exec", S_JUMP, C_JUMP);

    // FETCH stalled 3 cycles, completes on the 4th
    opcode    = OP_RTYPE;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("fetch_stall", S_FETCH, C_FETCH_WT);
    mem_ready = 1'b1;
    cyc("fetch_done", S_FETCH, C_FETCH_RDY);
    cyc("stall_decode", S_DECODE, C_DECODE);
    cyc("stall_r_ex", S_RTYPE_EX, C_RTYPE_EX);
    cyc("stall_r_wb", S_RTYPE_WB, C_RTYPE_WB);

    // lw with MEMRD stalled 15 cycles, ready on the 16th: still normal
    opcode = OP_LW;
    cyc("lwb_fetch", S_FETCH, C_FETCH_RDY);
    cyc("lwb_decode", S_DECODE, C_DECODE);
    cyc("lwb_memadr", S_MEMADR, C_MEMADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc("lwb_wait", S_MEMRD, C_MEMRD);
    mem_ready = 1'b1;
    cyc("lwb_last_ready", S_MEMRD, C_MEMRD);
    cyc("lwb_memwb", S_MEMWB, C_MEMWB);
    #1;
    check("lwb_no_trap", 32'(trap), 32'd0);

    // sw with MEMWR stalled 16 cycles: timeout to TRAP
    opcode = OP_SW;
    cyc("swt_fetch", S_FETCH, C_FETCH_RDY);
    cyc("swt_decode", S_DECODE, C_DECODE);
    cyc("swt_memadr", S_MEMADR, C_MEMADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc("swt_wait", S_MEMWR, C_MEMWR);
    #1;
    check("swt_trap", 32'(trap), 32'd1);
    mem_ready = 1'b1;
    cyc("swt_trapped", S_TRAP, C_NONE);
    cyc("swt_trap_hold", S_TRAP, C_NONE);
    check("swt_trap_sticky", 32'(trap), 32'd1);
    do_reset();

    // illegal opcode
    opcode = 6'b111111;
    cyc("ill_fetch", S_FETCH, C_FETCH_RDY);
    cyc("ill_decode", S_DECODE, C_DECODE);
    cyc("ill_trapped", S_TRAP, C_NONE);
    check("ill_trap", 32'(trap), 32'd1);
    do_reset();

    // reset mid-wait in MEMRD, then prove the wait counter restarted at 0
    opcode = OP_LW;
    cyc("rmw_fetch", S_FETCH, C_FETCH_RDY);
    cyc("rmw_decode", S_DECODE, C_DECODE);
    cyc("rmw_memadr", S_MEMADR, C_MEMADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc("rmw_wait", S_MEMRD, C_MEMRD);
    rst = 1'b1;
    tick();
    #1;
    check("rmw_rst_state", 32'(state), 32'(S_FETCH));
    check("rmw_rst_ctrl", 32'(ctrl), 32'(C_FETCH_WT));
    rst = 1'b0;
    for (int i = 0; i < 16; i++) cyc("rmw_fetch_wait", S_FETCH, C_FETCH_WT);
    #1;
    check("rmw_fetch_tmo", 32'(state), 32'(S_TRAP));
    check("rmw_trap", 32'(trap), 32'd1);
    mem_ready = 1'b1;
    do_reset();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
